// File: rtl/ps2_packet_parser_param.sv
// Parametrised PS/2-style packet framer: locks on a sync bit in the first byte and
// assembles PKT_BYTES bytes into one word, with an optional inter-byte idle abort.
module ps2_packet_parser_param #(
  parameter int DATA_W      = 8,
  parameter int PKT_BYTES   = 3,
  parameter int SYNC_BIT    = 3,
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           in_i,
  input  logic                        in_valid_i,
  output logic [DATA_W*PKT_BYTES-1:0] out_bytes_o,
  output logic                        done_o,
  output logic                        timeout_o,
  output logic [7:0]                  drop_cnt_o,
  output logic [CNT_W-1:0]            pkt_cnt_o
);

  localparam int PKT_W  = DATA_W * PKT_BYTES;
  localparam int IDX_W  = $clog2(PKT_BYTES);
  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PKT_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic {
    S_SEARCH  = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [PKT_W-1:0]    shift_q, shift_d;
  logic [PKT_W-1:0]    out_q, out_d;
  logic                done_q, done_d;
  logic                to_q, to_d;
  logic [7:0]          drop_q, drop_d;
  logic [CNT_W-1:0]    pkt_q, pkt_d;
  logic [PKT_W-1:0]    shift_in;

  // Oldest byte migrates toward the MSBs as new bytes enter at the bottom.
  assign shift_in = {shift_q[PKT_W-DATA_W-1:0], in_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SEARCH;
      idx_q   <= '0;
      idle_q  <= '0;
      shift_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      drop_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      done_q  <= done_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
      pkt_q   <= pkt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    shift_d = shift_q;
    out_d   = out_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    drop_d  = drop_q;
    pkt_d   = pkt_q;
    unique case (state_q)
      S_SEARCH: begin
        if (in_valid_i) begin
          if (in_i[SYNC_BIT]) begin
            shift_d = shift_in;
            idx_d   = IDX_W'(1);
            idle_d  = '0;
            state_d = S_COLLECT;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      S_COLLECT: begin
        if (in_valid_i) begin
          shift_d = shift_in;
          idle_d  = '0;
          if (idx_q == IDX_LAST) begin
            out_d   = shift_in;
            pkt_d   = pkt_q + CNT_W'(1);
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = S_SEARCH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (TIMEOUT_CYC > 0) begin
          // A byte in the same cycle always beats the abort; only idle cycles count here.
          if (idle_q == IDLE_LAST) begin
            idle_d  = '0;
            idx_d   = '0;
            to_d    = 1'b1;
            state_d = S_SEARCH;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  assign out_bytes_o = out_q;
  assign done_o      = done_q;
  assign timeout_o   = to_q;
  assign drop_cnt_o  = drop_q;
  assign pkt_cnt_o   = pkt_q;

endmodule

// File: tb/tb_ps2_packet_parser_param.sv
// Bench for ps2_packet_parser_param: three configurations, directed scenarios plus
// randomized traffic on the timeout build checked against a queue-based packet model.
module tb_ps2_packet_parser_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // u0: default widths, TIMEOUT_CYC=4, small packet counter so wrap is exercised
  logic        a_r = 1'b1, a_v = 1'b0;
  logic [7:0]  a_b = '0;
  logic [23:0] a_out;
  logic        a_done, a_to;
  logic [7:0]  a_drop;
  logic [3:0]  a_pkt;

  ps2_packet_parser_param #(.TIMEOUT_CYC(4), .CNT_W(4)) u0 (
    .clk(clk), .reset(a_r), .in_i(a_b), .in_valid_i(a_v),
    .out_bytes_o(a_out), .done_o(a_done), .timeout_o(a_to),
    .drop_cnt_o(a_drop), .pkt_cnt_o(a_pkt));

  // u1: all defaults
  logic        b_r = 1'b1, b_v = 1'b0;
  logic [7:0]  b_b = '0;
  logic [23:0] b_out;
  logic        b_done, b_to;
  logic [7:0]  b_drop;
  logic [15:0] b_pkt;

  ps2_packet_parser_param u1 (
    .clk(clk), .reset(b_r), .in_i(b_b), .in_valid_i(b_v),
    .out_bytes_o(b_out), .done_o(b_done), .timeout_o(b_to),
    .drop_cnt_o(b_drop), .pkt_cnt_o(b_pkt));

  // u2: 16-bit bytes, 2-byte packets, sync on the MSB
  logic        c_r = 1'b1, c_v = 1'b0;
  logic [15:0] c_b = '0;
  logic [31:0] c_out;
  logic        c_done, c_to;
  logic [7:0]  c_drop;
  logic [15:0] c_pkt;

  ps2_packet_parser_param #(.DATA_W(16), .PKT_BYTES(2), .SYNC_BIT(15)) u2 (
    .clk(clk), .reset(c_r), .in_i(c_b), .in_valid_i(c_v),
    .out_bytes_o(c_out), .done_o(c_done), .timeout_o(c_to),
    .drop_cnt_o(c_drop), .pkt_cnt_o(c_pkt));

  // Reference model for u0: a packet is just the list of bytes gathered so far.
  logic [7:0]  mq[$];
  int          m_idle = 0;
  logic [23:0] m_out = '0;
  logic        m_done = 1'b0, m_to = 1'b0;
  int          m_drop = 0, m_pkt = 0;

  task automatic s0(input logic v, input logic [7:0] b, input logic r);
    a_v = v; a_b = b; a_r = r;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_idle = 0; m_out = '0; m_done = 0; m_to = 0; m_drop = 0; m_pkt = 0;
    end else begin
      m_done = 0; m_to = 0;
      if (mq.size() == 0) begin
        if (v) begin
          if (b[3]) mq.push_back(b);
          else if (m_drop < 255) m_drop++;
        end
      end else if (v) begin
        mq.push_back(b);
        m_idle = 0;
        if (mq.size() == 3) begin
          m_out = {mq[0], mq[1], mq[2]};
          m_pkt = (m_pkt + 1) % 16;
          m_done = 1;
          mq.delete();
        end
      end else begin
        m_idle++;
        if (m_idle == 4) begin
          mq.delete(); m_idle = 0; m_to = 1;
        end
      end
    end
    #1;
    check("u0_out", 64'(a_out), 64'(m_out));
    check("u0_done", 64'(a_done), 64'(m_done));
    check("u0_timeout", 64'(a_to), 64'(m_to));
    check("u0_drop", 64'(a_drop), 64'(m_drop));
    check("u0_pkt", 64'(a_pkt), 64'(m_pkt));
  endtask

  task automatic s1(input logic v, input logic [7:0] b, input logic r);
    b_v = v; b_b = b; b_r = r;
    @(posedge clk); #1;
  endtask

  task automatic s2(input logic v, input logic [15:0] b, input logic r);
    c_v = v; c_b = b; c_r = r;
    @(posedge clk); #1;
  endtask

  initial begin
    // ---------- u1: defaults ----------
    s1(0, 8'h00, 1);
    check("u1_rst_out", 64'(b_out), 64'h0);
    check("u1_rst_done", 64'(b_done), 64'h0);
    check("u1_rst_drop", 64'(b_drop), 64'h0);
    check("u1_rst_pkt", 64'(b_pkt), 64'h0);
    s1(1, 8'h08, 0);
    s1(1, 8'h12, 0);
    check("u1_no_early_done", 64'(b_done), 64'h0);
    s1(1, 8'h34, 0);
    check("u1_done1", 64'(b_done), 64'h1);
    check("u1_out1", 64'(b_out), 64'h081234);
    check("u1_pkt1", 64'(b_pkt), 64'h1);
    s1(0, 8'h00, 0);
    check("u1_done_pulse", 64'(b_done), 64'h0);
    check("u1_out_hold", 64'(b_out), 64'h081234);
    s1(1, 8'h00, 0);
    s1(1, 8'h01, 0);
    s1(1, 8'h08, 0);
    s1(1, 8'hAA, 0);
    check("u1_partial_hidden", 64'(b_out), 64'h081234);
    s1(1, 8'hBB, 0);
    check("u1_drop2", 64'(b_drop), 64'h2);
    check("u1_done2", 64'(b_done), 64'h1);
    check("u1_out2", 64'(b_out), 64'h08AABB);
    check("u1_pkt2", 64'(b_pkt), 64'h2);
    s1(1, 8'h08, 0);
    s1(1, 8'h11, 0);
    for (int i = 0; i < 5; i++) begin
      s1(0, 8'hFF, 0);
      check("u1_no_timeout", 64'(b_to), 64'h0);
    end
    s1(1, 8'h22, 0);
    check("u1_done3", 64'(b_done), 64'h1);
    check("u1_out3", 64'(b_out), 64'h081122);
    b_v = 0;

    // ---------- u0: timeout scenarios, model-checked plus explicit values ----------
    s0(0, 8'h00, 1);
    s0(1, 8'h08, 0);
    s0(1, 8'h11, 0);
    for (int i = 0; i < 3; i++) begin
      s0(0, 8'h00, 0);
      check("u0_to_early", 64'(a_to), 64'h0);
    end
    s0(0, 8'h00, 0);
    check("u0_to_fire", 64'(a_to), 64'h1);
    check("u0_to_out_kept", 64'(a_out), 64'h0);
    s0(0, 8'h00, 0);
    check("u0_to_pulse", 64'(a_to), 64'h0);
    s0(1, 8'h0C, 0);
    s0(1, 8'h33, 0);
    s0(1, 8'h44, 0);
    check("u0_after_to", 64'(a_out), 64'h0C3344);
    s0(1, 8'h08, 0);
    for (int i = 0; i < 3; i++) s0(0, 8'h00, 0);
    s0(1, 8'h55, 0);
    check("u0_byte_beats_to", 64'(a_to), 64'h0);
    s0(1, 8'h66, 0);
    check("u0_out_race", 64'(a_out), 64'h085566);
    // drop counter saturation
    for (int i = 0; i < 300; i++) s0(1, 8'h00, 0);
    check("u0_drop_sat", 64'(a_drop), 64'd255);
    // randomized traffic with idle bursts and occasional reset
    s0(0, 8'h00, 1);
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel == 0) s0(0, 8'($urandom), 1);
      else if (sel < 6) begin
        int n;
        n = $urandom_range(3, 6);
        for (int k = 0; k < n; k++) s0(0, 8'($urandom), 0);
      end else if (sel < 30) s0(0, 8'($urandom), 0);
      else s0(1, 8'($urandom), 0);
    end
    a_v = 0;

    // ---------- u2: 16-bit, 2-byte packets ----------
    s2(0, 16'h0000, 1);
    check("u2_rst_out", 64'(c_out), 64'h0);
    s2(1, 16'h8001, 0);
    s2(1, 16'h1234, 0);
    check("u2_done1", 64'(c_done), 64'h1);
    check("u2_out1", 64'(c_out), 64'h80011234);
    s2(1, 16'h8002, 0);
    check("u2_b2b_gap", 64'(c_done), 64'h0);
    s2(1, 16'h5678, 0);
    check("u2_done2", 64'(c_done), 64'h1);
    check("u2_out2", 64'(c_out), 64'h80025678);
    check("u2_pkt2", 64'(c_pkt), 64'h2);
    s2(1, 16'h8003, 0);
    s2(1, 16'h9999, 1);
    check("u2_rst_done", 64'(c_done), 64'h0);
    check("u2_rst_to", 64'(c_to), 64'h0);
    check("u2_rst_pkt", 64'(c_pkt), 64'h0);
    s2(1, 16'h4444, 0);
    check("u2_rst_no_done", 64'(c_done), 64'h0);
    check("u2_drop_after_rst", 64'(c_drop), 64'h1);
    c_v = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
